// File: rtl/wait_state_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wait_state_responder
//  Purpose  : Avalon-style memory-mapped responder with a small 16-bit
//             register bank. Every access is stalled for a fixed number of
//             wait states with Waitreq, then acknowledged for one cycle.
//             Out-of-window and read+write requests are acknowledged but
//             counted in a saturating error counter.
//  Ports    : Clock     - system clock, rising edge
//             Resetn    - asynchronous active-low reset
//             ReadData  - read strobe from the initiator
//             WriteData - write strobe from the initiator
//             DataAddr  - 16-bit word address
//             DataOut   - write data from the initiator
//             DataIn    - read data to the initiator
//             Waitreq   - high while the current request is incomplete
//             ErrCount  - saturating count of erroneous requests
//  Revision : 1.0 - initial release
// ============================================================================
module wait_state_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h1000,
    parameter int unsigned ADDR_BITS   = 4,
    parameter int unsigned WAIT_CYCLES = 2      // legal range 1..15
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        ReadData,
    input  logic        WriteData,
    input  logic [15:0] DataAddr,
    input  logic [15:0] DataOut,
    output logic [15:0] DataIn,
    output logic        Waitreq,
    output logic [7:0]  ErrCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_ACK  = 2'd2;

    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic        rd_q,      rd_d;
    logic        wr_q,      wr_d;
    logic [15:0] addr_q,    addr_d;
    logic [15:0] wdata_q,   wdata_d;
    logic [15:0] data_in_q, data_in_d;
    logic [7:0]  err_q,     err_d;
    logic [15:0] bank_q [DEPTH];
    logic [15:0] bank_d [DEPTH];

    logic                 w_req;
    logic [15:0]          w_offset;
    logic                 w_in_window;
    logic [ADDR_BITS-1:0] w_index;
    logic [7:0]           w_err_inc;

    assign w_req = ReadData | WriteData;

    // A single modular subtraction decodes the window: addresses below the
    // base wrap to a large offset and fall outside, as long as the window
    // itself does not straddle the top of the 16-bit address space.
    assign w_offset    = addr_q - BASE_ADDR;
    assign w_in_window = (32'(w_offset) < DEPTH);
    assign w_index     = w_offset[ADDR_BITS-1:0];

    assign w_err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_in_d = data_in_q;
        err_d     = err_q;
        bank_d    = bank_q;

        case (state_q)
            c_IDLE: begin
                if (w_req) begin
                    rd_d    = ReadData;
                    wr_d    = WriteData;
                    addr_d  = DataAddr;
                    wdata_d = DataOut;
                    cnt_d   = c_CNT_INIT;
                    state_d = c_WAIT;
                end
            end

            c_WAIT: begin
                if (!w_req) begin
                    // Initiator abandoned the request: nothing commits.
                    state_d = c_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = c_ACK;
                    // The access itself is performed on the edge into ACK,
                    // using only the copies latched in IDLE.
                    if (rd_q && wr_q) begin
                        data_in_d = 16'hFFFF;
                        err_d     = w_err_inc;
                    end else if (!w_in_window) begin
                        err_d = w_err_inc;
                        if (rd_q) begin
                            data_in_d = 16'h0000;
                        end
                    end else if (rd_q) begin
                        data_in_d = bank_q[w_index];
                    end else begin
                        bank_d[w_index] = wdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            c_ACK: begin
                // Always pass through IDLE so a held strobe is re-sampled
                // as a fresh request.
                state_d = c_IDLE;
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= c_IDLE;
            cnt_q     <= 4'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            data_in_q <= 16'h0000;
            err_q     <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_in_q <= data_in_d;
            err_q     <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign Waitreq  = w_req & (state_q != c_ACK);
    assign DataIn   = data_in_q;
    assign ErrCount = err_q;

endmodule
`default_nettype wire
